// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and default widths for the APB initiator.
//               Holds the state encoding, the request/response bundles and
//               the default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int c_apb_addr_w = 32;
    localparam int c_apb_data_w = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [c_apb_addr_w-1:0] addr;
        logic [c_apb_data_w-1:0] wdata;
        logic                    write;
    } apb_req_t;

    typedef struct packed {
        logic [c_apb_data_w-1:0] rdata;
        logic                    slverr;
    } apb_resp_t;

endpackage

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// Module      : apb_master
// Description : APB initiator. Takes single read/write commands on a
//               valid/ready request channel, runs the APB SETUP/ACCESS
//               phases, waits on pready and returns read data plus error
//               status on a valid/ready response channel.
// Revision    : 1.0 - initial release
//
// Parameters  : ADDR_W         - paddr / req_addr width
//               DATA_W         - pwdata / prdata / req_wdata / resp_rdata width
//               TIMEOUT_CYCLES - ACCESS-phase cycle limit (>= 1), only used
//                                when APB_MASTER_TIMEOUT_EN is defined
//
// Build macro : APB_MASTER_TIMEOUT_EN - adds an ACCESS-phase watchdog that
//               ends a stalled transfer with resp_slverr = 1.
//
// Ports       : pclk, presetn        - clock, synchronous active-low reset
//               req_valid/req_ready  - command handshake
//               req_addr/req_wdata/req_write - command payload
//               resp_valid/resp_ready - response handshake
//               resp_rdata/resp_slverr - response payload
//               paddr/pwdata/pwrite/psel/penable - APB requester outputs
//               prdata/pready/pslverr - APB completer inputs
// ============================================================================
`default_nettype none

module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = c_apb_addr_w,
    parameter int DATA_W         = c_apb_data_w,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_write,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_slverr,

    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [1:0] c_st_idle   = IDLE;
    localparam logic [1:0] c_st_setup  = SETUP;
    localparam logic [1:0] c_st_access = ACCESS;
    localparam logic [1:0] c_st_resp   = RESP;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("apb_master: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_slverr;

    logic              w_expire;
    logic              w_complete;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_slverr_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Expiry fires on the edge that would make the count of stalled ACCESS
    // cycles equal TIMEOUT_CYCLES; pready on that edge still wins.
    assign w_expire = (r_state == c_st_access) && !pready &&
                      (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_cnt <= '0;
        end else if (r_state == c_st_setup) begin
            r_cnt <= '0;
        end else if ((r_state == c_st_access) && !pready) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    assign w_complete   = (r_state == c_st_access) && (pready || w_expire);
    // A timed-out transfer has no valid prdata, so it reports zero data.
    assign w_rdata_nxt  = (pready && !r_pwrite) ? prdata : '0;
    assign w_slverr_nxt = pready ? pslverr : 1'b1;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state       <= c_st_idle;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_slverr <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_paddr   <= req_addr;
                        r_pwdata  <= req_wdata;
                        r_pwrite  <= req_write;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_penable <= 1'b1;
                    r_state   <= c_st_access;
                end
                c_st_access: begin
                    if (w_complete) begin
                        r_resp_rdata  <= w_rdata_nxt;
                        r_resp_slverr <= w_slverr_nxt;
                        r_resp_valid  <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == c_st_idle);
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_slverr = r_resp_slverr;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pwrite      = r_pwrite;
    assign psel        = r_psel;
    assign penable     = r_penable;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module      : tb_apb_master
// Description : Self-checking bench for apb_master. Directed steps in one
//               initial block; expected responses are queued when a command
//               is driven and compared when the response handshake occurs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          slverr;
    } exp_t;

    logic          pclk;
    logic          presetn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_write;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_slverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    apb_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_write   (req_write),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_slverr (resp_slverr),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] rdata, input logic slverr);
        exp_t e;
        e.rdata  = rdata;
        e.slverr = slverr;
        exp_q.push_back(e);
    endtask

    // Scoreboard: a handshake seen mid-cycle completes on the next edge.
    always @(negedge pclk) begin
        if (presetn && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_resp observed rdata=0x%0h slverr=%0b expected no response",
                       resp_rdata, resp_slverr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_rdata", 64'(resp_rdata), 64'(e.rdata));
                check("sb_slverr", 64'(resp_slverr), 64'(e.slverr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int   first_rise;
    int   second_rise;
    logic prev_psel;
    int   hits;
    int   lat;

    initial begin
        checks    = 0;
        failures  = 0;
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        resp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        tick(); tick(); tick();

        // ---------------- reset state ----------------
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_slverr", 64'(resp_slverr), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        presetn = 1'b1;
        tick();

        // ---------------- write, no wait states ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'hA5A5_5A5A;
        req_write = 1'b1;
        pready    = 1'b1;             // early pready must be ignored
        prdata    = 32'hDEAD_BEEF;    // must not reach resp_rdata on a write
        push_exp(32'h0, 1'b0);
        check("wr_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("wr_setup_psel", 64'(psel), 64'd1);
        check("wr_setup_penable", 64'(penable), 64'd0);
        check("wr_paddr", 64'(paddr), 64'h10);
        check("wr_pwdata", 64'(pwdata), 64'hA5A5_5A5A);
        check("wr_pwrite", 64'(pwrite), 64'd1);
        tick();
        check("wr_access_psel", 64'(psel), 64'd1);
        check("wr_access_penable", 64'(penable), 64'd1);
        check("wr_access_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        check("wr_done_psel", 64'(psel), 64'd0);
        check("wr_done_penable", 64'(penable), 64'd0);
        check("wr_resp_valid_n3", 64'(resp_valid), 64'd1);
        check("wr_resp_rdata", 64'(resp_rdata), 64'd0);
        check("wr_resp_slverr", 64'(resp_slverr), 64'd0);
        check("wr_paddr_hold", 64'(paddr), 64'h10);
        pready     = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("wr_resp_cleared", 64'(resp_valid), 64'd0);
        check("wr_idle", 64'(req_ready), 64'd1);

        // ---------------- read with three wait states ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h0000_0055;
        req_write = 1'b0;
        prdata    = 32'h0;
        push_exp(32'h1234_5678, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_psel", 64'(psel), 64'd1);
            check("rd_wait_penable", 64'(penable), 64'd1);
            check("rd_wait_paddr", 64'(paddr), 64'h4);
            check("rd_wait_pwrite", 64'(pwrite), 64'd0);
            check("rd_wait_resp_valid", 64'(resp_valid), 64'd0);
            tick();
        end
        pready = 1'b1;
        prdata = 32'h1234_5678;
        tick();
        pready = 1'b0;
        prdata = 32'hFFFF_0000;
        check("rd_resp_valid_n6", 64'(resp_valid), 64'd1);
        check("rd_resp_rdata", 64'(resp_rdata), 64'h1234_5678);
        tick();
        check("rd_rdata_held", 64'(resp_rdata), 64'h1234_5678);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // ---------------- error with response backpressure ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_0020;
        req_write = 1'b0;
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("err_resp_valid", 64'(resp_valid), 64'd1);
            check("err_resp_slverr", 64'(resp_slverr), 64'd1);
            check("err_req_ready", 64'(req_ready), 64'd0);
            if (i < 4) tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("err_idle", 64'(req_ready), 64'd1);
        check("err_resp_cleared", 64'(resp_valid), 64'd0);

        // ---------------- back-to-back with held req_valid ----------------
        resp_ready = 1'b1;
        pready     = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0008;
        req_wdata  = 32'h1111_2222;
        req_write  = 1'b1;
        prdata     = 32'h0BAD_CAFE;
        push_exp(32'h0, 1'b0);
        prev_psel   = psel;
        first_rise  = -1;
        second_rise = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (psel && !prev_psel) begin
                if (first_rise < 0) begin
                    first_rise = k;
                end else if (second_rise < 0) begin
                    second_rise = k;
                    req_valid = 1'b0;
                    check("b2b_second_paddr", 64'(paddr), 64'hC);
                    check("b2b_second_pwrite", 64'(pwrite), 64'd0);
                end
            end
            prev_psel = psel;
            if (k == 1) begin
                req_addr  = 32'h0000_000C;
                req_write = 1'b0;
                push_exp(32'h0BAD_CAFE, 1'b0);
            end
        end
        check("b2b_first_rise", 64'(first_rise), 64'd1);
        check("b2b_spacing", 64'(second_rise - first_rise), 64'd4);
        check("b2b_idle", 64'(req_ready), 64'd1);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        resp_ready = 1'b0;
        pready     = 1'b0;

        // ---------------- reset mid-ACCESS ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_0030;
        req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rstm_in_access", 64'(penable), 64'd1);
        presetn = 1'b0;
        tick();
        check("rstm_psel", 64'(psel), 64'd0);
        check("rstm_penable", 64'(penable), 64'd0);
        check("rstm_resp_valid", 64'(resp_valid), 64'd0);
        check("rstm_paddr", 64'(paddr), 64'd0);
        presetn    = 1'b1;
        pready     = 1'b1;
        resp_ready = 1'b1;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (resp_valid || psel) hits++;
        end
        check("rstm_no_response", 64'(hits), 64'd0);
        pready     = 1'b0;
        resp_ready = 1'b0;

        // ---------------- stalled ACCESS ----------------
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        req_write = 1'b0;
        prdata    = 32'h7777_7777;
`ifdef APB_MASTER_TIMEOUT_EN
        push_exp(32'h0, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
            if (resp_valid && lat == 0) lat = k;
        end
        check("to_latency_n6", 64'(lat), 64'd6);
        check("to_resp_slverr", 64'(resp_slverr), 64'd1);
        check("to_resp_rdata", 64'(resp_rdata), 64'd0);
        check("to_psel", 64'(psel), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
`else
        hits = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
            if (resp_valid) hits++;
        end
        check("nto_no_response", 64'(hits), 64'd0);
        check("nto_still_waiting", 64'(psel & penable), 64'd1);
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        tick();
`endif
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
